sipo_frame_rx: RTL

SIPO_FRAME_RX -- requirements
Module: sipo_frame_rx

---
 rtl/sipo_frame_rx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start(1), DATA_W bits LSB first, optional even parity, stop(0).
// Parity stage is built only when SIPO_FRAME_RX_PARITY_EN is defined; parity_err is tied low otherwise.
module sipo_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

`ifdef SIPO_FRAME_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     cnt;
    logic              eval;
    logic              eval_stop;
    logic              perr;
    logic              good;

`ifdef SIPO_FRAME_RX_PARITY_EN
    logic par_bit;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (sin) state_nx = DATA;
            DATA: begin
                if (cnt == LAST_BIT) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
                end
            end
`ifdef SIPO_FRAME_RX_PARITY_EN
            PARITY: state_nx = STOP;
`endif
            STOP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Frame evaluation happens the cycle after the stop sample; shreg is not
    // disturbed then because a new frame's first data bit comes one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            cnt       <= '0;
            eval      <= 1'b0;
            eval_stop <= 1'b0;
        end else begin
            eval <= 1'b0;
            case (state)
                IDLE: cnt <= '0;
                DATA: begin
                    shreg <= {sin, shreg[DATA_W-1:1]};
                    cnt   <= cnt + 1'b1;
                end
                STOP: begin
                    eval      <= 1'b1;
                    eval_stop <= sin;
                end
                default: ;
            endcase
        end
    end

`ifdef SIPO_FRAME_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (state == PARITY) begin
            par_bit <= sin;
        end
    end

    assign perr = ^{shreg, par_bit};
`else
    assign perr = 1'b0;
`endif

    assign good = eval && !eval_stop && !perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= eval && eval_stop;
            parity_err <= eval && perr;
            overrun    <= good && valid && !ready;
            if (good && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
